// File: rtl/dp_issue_ctrl_if.sv
// Bundle of instruction-offer, ALU-drive and writeback signals for dp_issue_ctrl.
// slave = the sequencer itself; master = decode stage, ALU and register file side.
interface dp_issue_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             instr_valid;
   logic             instr_ready;
   logic [31:0]      instr;
   logic [WIDTH-1:0] rn_data;
   logic [WIDTH-1:0] op2_data;
   logic             shifter_carry;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [4:0]       alu_opcode;
   logic             alu_carry;
   logic [WIDTH-1:0] alu_result;
   logic             alu_z;
   logic             alu_n;
   logic             alu_c;
   logic             alu_v;
   logic             wb_valid;
   logic [3:0]       wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic [3:0]       flags;
   logic             cond_skip;

   modport slave (
      input  instr_valid, instr, rn_data, op2_data, shifter_carry,
      input  alu_result, alu_z, alu_n, alu_c, alu_v,
      output instr_ready, alu_a, alu_b, alu_opcode, alu_carry,
      output wb_valid, wb_rd, wb_data, flags, cond_skip
   );

   modport master (
      output instr_valid, instr, rn_data, op2_data, shifter_carry,
      output alu_result, alu_z, alu_n, alu_c, alu_v,
      input  instr_ready, alu_a, alu_b, alu_opcode, alu_carry,
      input  wb_valid, wb_rd, wb_data, flags, cond_skip
   );
endinterface

// File: rtl/dp_issue_ctrl.sv
// Issue sequencer for ARM data-processing ops: condition check, ALU drive, writeback, NZCV.
// Optional macro DP_FLAG_FWD_EN: accept in WB with flag bypass (one instruction per 2 cycles).
module dp_issue_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            reset,
   dp_issue_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_ready;
   logic             w_accept;
   logic             w_pass;
   logic [3:0]       w_op;
   logic [3:0]       w_cur_flags;
   logic [3:0]       w_flags_new;
   logic             w_upd;
   logic             w_arith;
   logic             w_cmp;
   logic             w_unused_bits;

   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [4:0]       r_alu_opcode;
   logic             r_alu_carry;
   logic [3:0]       r_op;
   logic             r_s;
   logic [3:0]       r_rd;
   logic             r_shc;
   logic [WIDTH-1:0] r_res;
   logic             r_ln, r_lz, r_lc, r_lv;
   logic [3:0]       r_flags;
   logic             r_skip;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0:    cond_pass = z;
         4'h1:    cond_pass = !z;
         4'h2:    cond_pass = cy;
         4'h3:    cond_pass = !cy;
         4'h4:    cond_pass = n;
         4'h5:    cond_pass = !n;
         4'h6:    cond_pass = v;
         4'h7:    cond_pass = !v;
         4'h8:    cond_pass = cy & !z;
         4'h9:    cond_pass = !cy | z;
         4'hA:    cond_pass = (n == v);
         4'hB:    cond_pass = (n != v);
         4'hC:    cond_pass = !z & (n == v);
         4'hD:    cond_pass = z | (n != v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign w_op          = bus.instr[24:21];
   assign w_unused_bits = ^{bus.instr[27:25], bus.instr[19:16], bus.instr[11:0]};

   // Flag update for the instruction currently in WB
   assign w_cmp       = (r_op[3:2] == 2'b10);
   assign w_arith     = (r_op[3:2] == 2'b01) | (r_op[3:1] == 3'b001) | (r_op[3:1] == 3'b101);
   assign w_upd       = (r_state == S_WB) & (r_s | w_cmp);
   assign w_flags_new = {r_ln, r_lz, w_arith ? r_lc : r_shc, w_arith ? r_lv : r_flags[0]};

`ifdef DP_FLAG_FWD_EN
   assign w_cur_flags = w_upd ? w_flags_new : r_flags;
`else
   assign w_cur_flags = r_flags;
`endif

   assign w_pass = cond_pass(bus.instr[31:28], w_cur_flags);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      case (r_state)
         S_IDLE: w_ready = 1'b1;
         S_EXEC: w_state_next = S_WB;
         S_WB: begin
            w_state_next = S_IDLE;
`ifdef DP_FLAG_FWD_EN
            w_ready = 1'b1;
`endif
         end
         default: w_state_next = S_IDLE;
      endcase
      w_ready  = w_ready & !reset;
      w_accept = bus.instr_valid & w_ready;
      if (w_accept && w_pass) w_state_next = S_EXEC;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_opcode <= '0;
         r_alu_carry  <= 1'b0;
         r_op         <= '0;
         r_s          <= 1'b0;
         r_rd         <= '0;
         r_shc        <= 1'b0;
         r_res        <= '0;
         {r_ln, r_lz, r_lc, r_lv} <= '0;
         r_flags      <= '0;
         r_skip       <= 1'b0;
      end else begin
         r_skip <= w_accept & !w_pass;
         if (w_accept && w_pass) begin
            r_alu_a <= bus.rn_data;
            r_alu_b <= bus.op2_data;
            case (w_op)
               4'b1000: r_alu_opcode <= 5'b00000;
               4'b1001: r_alu_opcode <= 5'b00001;
               4'b1010: r_alu_opcode <= 5'b00010;
               4'b1011: r_alu_opcode <= 5'b00100;
               default: r_alu_opcode <= {1'b0, w_op};
            endcase
            r_alu_carry <= (w_op == 4'b0101 || w_op == 4'b0110 || w_op == 4'b0111) ?
                           w_cur_flags[1] : bus.shifter_carry;
            r_op  <= w_op;
            r_s   <= bus.instr[20];
            r_rd  <= bus.instr[15:12];
            r_shc <= bus.shifter_carry;
         end
         if (r_state == S_EXEC) begin
            r_res <= bus.alu_result;
            {r_ln, r_lz, r_lc, r_lv} <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
         end
         if (w_upd) r_flags <= w_flags_new;
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_opcode  = r_alu_opcode;
   assign bus.alu_carry   = r_alu_carry;
   assign bus.wb_valid    = (r_state == S_WB) & !w_cmp;
   assign bus.wb_rd       = r_rd;
   assign bus.wb_data     = r_res;
   assign bus.flags       = r_flags;
   assign bus.cond_skip   = r_skip;
endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed bench for dp_issue_ctrl with a behavioural ALU and a writeback/skip scoreboard.
module tb_dp_issue_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   dp_issue_ctrl_if #(.WIDTH(32)) bus ();

   dp_issue_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU: ARM data-processing semantics, C = no-borrow for subtraction
   logic [32:0] alu_sum;
   logic [31:0] alu_x, alu_y;
   logic        alu_ci, alu_ar;
   always_comb begin
      alu_x = bus.alu_a; alu_y = bus.alu_b; alu_ci = 1'b0; alu_ar = 1'b1;
      case (bus.alu_opcode[3:0])
         4'b0010: begin alu_y = ~bus.alu_b; alu_ci = 1'b1; end
         4'b0011: begin alu_x = bus.alu_b; alu_y = ~bus.alu_a; alu_ci = 1'b1; end
         4'b0100: ;
         4'b0101: alu_ci = bus.alu_carry;
         4'b0110: begin alu_y = ~bus.alu_b; alu_ci = bus.alu_carry; end
         4'b0111: begin alu_x = bus.alu_b; alu_y = ~bus.alu_a; alu_ci = bus.alu_carry; end
         default: alu_ar = 1'b0;
      endcase
      alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {32'd0, alu_ci};
      case (bus.alu_opcode[3:0])
         4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
         4'b0001: bus.alu_result = bus.alu_a ^ bus.alu_b;
         4'b1100: bus.alu_result = bus.alu_a | bus.alu_b;
         4'b1101: bus.alu_result = bus.alu_b;
         4'b1110: bus.alu_result = bus.alu_a & ~bus.alu_b;
         4'b1111: bus.alu_result = ~bus.alu_b;
         default: bus.alu_result = alu_sum[31:0];
      endcase
      bus.alu_n = bus.alu_result[31];
      bus.alu_z = (bus.alu_result == 32'd0);
      bus.alu_c = alu_ar & alu_sum[32];
      bus.alu_v = alu_ar & (alu_x[31] == alu_y[31]) & (alu_sum[31] != alu_x[31]);
   end

   typedef struct {
      bit          skip;
      logic [3:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.wb_valid && bus.cond_skip) chk("wb_skip_overlap", 32'(bus.cond_skip), 32'd0);
      if (bus.wb_valid || bus.cond_skip) begin
         if (q.size() == 0) begin
            chk("unexpected_output", {30'd0, bus.wb_valid, bus.cond_skip}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("out_kind_skip", 32'(bus.cond_skip), 32'(mon_e.skip));
            chk("out_cycle", cyc, mon_e.cyc);
            if (!mon_e.skip) begin
               chk("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
               chk("wb_data", bus.wb_data, mon_e.data);
            end
         end
      end
   end

   task automatic send(input logic [31:0] w, input logic [31:0] rn, input logic [31:0] op2,
                       input logic shc, output int acc);
      int n = 0;
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.instr = w;
      bus.rn_data = rn; bus.op2_data = op2; bus.shifter_carry = shc;
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic run(input string nm, input logic [3:0] cond, input logic [3:0] op, input logic s,
                      input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2,
                      input logic shc, input logic pass, input logic [4:0] opc, input logic cy,
                      input logic [31:0] data, input logic [3:0] fl);
      int acc;
      exp_t e;
      logic [31:0] w;
      w = {cond, 3'b000, op, s, 4'h0, rd, 12'h000};
      send(w, rn, op2, shc, acc);
      if (!pass) begin
         e.skip = 1'b1; e.rd = '0; e.data = '0; e.cyc = acc;
         q.push_back(e);
         @(negedge clk);
      end else begin
         if (op[3:2] != 2'b10) begin
            e.skip = 1'b0; e.rd = rd; e.data = data; e.cyc = acc + 1;
            q.push_back(e);
         end
         @(negedge clk);
         chk({nm, "_opcode"}, 32'(bus.alu_opcode), 32'(opc));
         chk({nm, "_alu_a"}, bus.alu_a, rn);
         chk({nm, "_alu_b"}, bus.alu_b, op2);
         chk({nm, "_carry"}, 32'(bus.alu_carry), 32'(cy));
         @(negedge clk);
         @(negedge clk);
      end
      chk({nm, "_flags"}, 32'(bus.flags), 32'(fl));
      chk({nm, "_ready"}, 32'(bus.instr_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.rn_data = '0;
      bus.op2_data = '0; bus.shifter_carry = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.instr_ready), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_skip", 32'(bus.cond_skip), 32'd0);
      chk("rst_opcode", 32'(bus.alu_opcode), 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      reset = 1'b0;

      //  name     cond  op      S     rd    rn            op2           shc   pass  opc       cy    data          flags
      run("adds",  4'hE, 4'b0100, 1'b1, 4'd1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 5'b00100, 1'b0, 32'h80000000, 4'b1001);
      run("moveq", 4'h0, 4'b1101, 1'b0, 4'd2, 32'h0,        32'h00000011, 1'b0, 1'b0, 5'b0,     1'b0, 32'h0,        4'b1001);
      run("cmp",   4'hE, 4'b1010, 1'b1, 4'd0, 32'h5,        32'h5,        1'b0, 1'b1, 5'b00010, 1'b0, 32'h0,        4'b0110);
      run("adcs",  4'hE, 4'b0101, 1'b1, 4'd3, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 5'b00101, 1'b1, 32'h0,        4'b0110);
      run("adds2", 4'hE, 4'b0100, 1'b1, 4'd1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 5'b00100, 1'b0, 32'h80000000, 4'b1001);
      run("ands",  4'hE, 4'b0000, 1'b1, 4'd4, 32'hF0,       32'h0F,       1'b1, 1'b1, 5'b00000, 1'b1, 32'h0,        4'b0111);
      run("movne", 4'h1, 4'b1101, 1'b0, 4'd5, 32'h0,        32'h22,       1'b0, 1'b0, 5'b0,     1'b0, 32'h0,        4'b0111);
      run("addeq", 4'h0, 4'b0100, 1'b0, 4'd6, 32'h3,        32'h4,        1'b0, 1'b1, 5'b00100, 1'b0, 32'h7,        4'b0111);
      run("cmn",   4'hE, 4'b1011, 1'b1, 4'd0, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 5'b00100, 1'b0, 32'h0,        4'b0110);
      run("teq",   4'hE, 4'b1001, 1'b1, 4'd0, 32'h5,        32'h5,        1'b0, 1'b1, 5'b00001, 1'b0, 32'h0,        4'b0100);
      run("sbcs",  4'hE, 4'b0110, 1'b1, 4'd7, 32'd10,       32'd3,        1'b1, 1'b1, 5'b00110, 1'b0, 32'd6,        4'b0010);
      run("movnv", 4'hF, 4'b1101, 1'b0, 4'd8, 32'h0,        32'h33,       1'b0, 1'b0, 5'b0,     1'b0, 32'h0,        4'b0010);
      run("movhi", 4'h8, 4'b1101, 1'b0, 4'd8, 32'h0,        32'h55,       1'b0, 1'b1, 5'b01101, 1'b0, 32'h55,       4'b0010);
      run("sublt", 4'hB, 4'b0010, 1'b1, 4'd9, 32'h9,        32'h1,        1'b0, 1'b0, 5'b0,     1'b0, 32'h0,        4'b0010);

      // Reset while ADDS is in EXEC: instruction must vanish without writeback or flag change
      send({4'hE, 3'b000, 4'b0100, 1'b1, 4'h0, 4'd9, 12'h000}, 32'h1, 32'h1, 1'b0, acc);
      @(negedge clk);
      chk("rexec_opcode", 32'(bus.alu_opcode), 32'b00100);
      reset = 1'b1;
      @(negedge clk);
      chk("rexec_ready_in_reset", 32'(bus.instr_ready), 32'd0);
      chk("rexec_flags", 32'(bus.flags), 32'd0);
      chk("rexec_wb_valid", 32'(bus.wb_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rexec_ready_after", 32'(bus.instr_ready), 32'd1);
      chk("rexec_flags_after", 32'(bus.flags), 32'd0);

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dp_issue_ctrl.md
Name: dp_issue_ctrl

Overview:
- Sequencer on the driving side of the 32-bit data-processing ALU. Accepts one decoded ARM data-processing instruction with pre-fetched operands and evaluates its condition field against an internal NZCV register.
- For passing instructions: drives ALU opcode, operands and carry-in; captures result and flags; issues a register writeback; updates NZCV.
- Sits between the decode/operand-fetch stage and the register file.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept
- instr  in  32  data-processing instruction word
- rn_data  in  32  first operand (Rn value)
- op2_data  in  32  second operand, already shifted/immediate
- shifter_carry  in  1  shifter carry-out for op2
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_opcode  out  5  ALU operation select
- alu_carry  out  1  ALU carry-in
- alu_result  in  32  ALU result (combinational from alu_*)
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  4  destination register
- wb_data  out  32  writeback value
- flags  out  4  NZCV register {N,Z,C,V}
- cond_skip  out  1  one-cycle pulse: instruction accepted but condition failed

Behaviour:
- Reset (sync, high): state IDLE, flags=0000, alu_a/alu_b=0, alu_opcode=0, alu_carry=0, wb_valid=0, wb_rd=0, wb_data=0, cond_skip=0. instr_ready=0 while reset high. Reset mid-operation abandons the instruction: no writeback, no flag update.
- instr_ready=1 only in IDLE. Accept = instr_valid & instr_ready.
- Condition (instr[31:28]) is evaluated on the current flags at accept. Codes:
  - EQ/NE: Z
  - CS/CC: C
  - MI/PL: N
  - VS/VC: V
  - HI: C&!Z; LS: !C|Z
  - GE: N==V; LT: N!=V
  - GT: !Z&(N==V); LE: Z|(N!=V)
  - AL: true; 1111: never
- Condition fail: cond_skip=1 next cycle; state stays IDLE; nothing issued.
- Condition pass: IDLE->EXEC.
- ALU opcode from op=instr[24:21]:
  - Non-compare ops: alu_opcode={0,op}.
  - Compares issue the computing op: TST(1000)->00000, TEQ(1001)->00001, CMP(1010)->00010, CMN(1011)->00100.
  - alu_a=rn_data, alu_b=op2_data, registered at accept.
- alu_carry: flags.C for ADC/SBC/RSC; shifter_carry otherwise.
- EXEC (1 cycle): ALU inputs held stable. At end of cycle, latch alu_result and alu_{n,z,c,v}. EXEC->WB.
- WB (1 cycle):
  - Writeback: wb_valid=1, wb_rd=instr[15:12], wb_data=latched result. Suppressed for compares (op 10xx).
  - Flag update when S=instr[20]=1 or the op is a compare. Values registered at end of WB:
    - N, Z from ALU.
    - Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): C, V from ALU.
    - Logical ops: C=latched shifter_carry, V unchanged.
  - WB->IDLE.
- Latency: accept at cycle N -> wb_valid and new flags visible at N+2. Throughput: one per 3 cycles.
- wb_valid and cond_skip are never asserted together.

Optional Feature:
- Macro DP_FLAG_FWD_EN.
- Defined:
  - instr_ready also asserted in WB.
  - An instruction accepted in WB evaluates its condition, and takes its ADC/SBC/RSC carry, from the flags being written that cycle (bypass).
  - Back-to-back throughput is one per 2 cycles; WB->EXEC directly on accept.
- Undefined: behaviour exactly as above.

Test Plan:
- ADDS r1: rn=0x7FFFFFFF, op2=1, cond=AL -> alu_opcode=00100, wb_valid at N+2, wb_rd=1, wb_data=0x80000000, flags=1001.
- CMP: rn=5, op2=5 -> alu_opcode=00010, no wb_valid, flags Z=1 C=1 N=0 V=0.
- Condition fail: flags Z=0, then MOVEQ r2 -> cond_skip=1 at N+1; no wb_valid; flags unchanged; instr_ready stays 1.
- ADCS: prior flags C=1, rn=0xFFFFFFFF, op2=0 -> alu_carry=1, wb_data=0, flags Z=1 C=1 V=0.
- ANDS: rn=0xF0, op2=0x0F, shifter_carry=1, prior V=1 -> wb_data=0, flags N=0 Z=1 C=1 V=1.
- Reset in EXEC of ADD -> no wb_valid, flags=0000, instr_ready=1 the cycle after reset deasserts.
